// File: rtl/vga_cache_pkg.sv
// Shared types and sizing for the VGA pixel cache.
package vga_cache_pkg;

   localparam int unsigned PIX_W        = 16;
   localparam int unsigned CACHE_ADDR_W = 10;

   // RGB565 field widths
   localparam int unsigned RGB_R_W = 5;
   localparam int unsigned RGB_G_W = 6;
   localparam int unsigned RGB_B_W = 5;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } cache_state_e;

   typedef struct packed {
      logic [RGB_R_W-1:0] r;
      logic [RGB_G_W-1:0] g;
      logic [RGB_B_W-1:0] b;
   } rgb565_t;

endpackage

// File: rtl/vga_cache_ram.sv
// Simple dual-port synchronous array with a registered read port.
// A same-cycle write to the address being read is forwarded so that a
// word written into an empty cache shows up one cycle later.
module vga_cache_ram
   import vga_cache_pkg::*;
#(
   parameter int unsigned DATA_W = PIX_W,
   parameter int unsigned ADDR_W = CACHE_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Storage write port (contents intentionally not reset)
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Registered read with write-through forwarding; holds when not enabled
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_rdata <= '0;
      else if (i_re)
         r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_pixel_cache.sv
// Show-ahead pixel FIFO between camera capture and VGA output.
// A FILL/STREAM state machine holds off CACHE_RD_EN until RD_THRESH words
// are buffered; FRAME_SYNC flushes everything at each frame boundary.
// Optional drop/starve counters: define VGA_CACHE_STAT_EN.
module vga_pixel_cache
   import vga_cache_pkg::*;
#(
   parameter int unsigned DATA_W    = PIX_W,
   parameter int unsigned ADDR_W    = CACHE_ADDR_W,
   parameter int unsigned RD_THRESH = 512
) (
   input  logic              CLK_40M,
   input  logic              RST_N,
   input  logic              FRAME_SYNC,
   input  logic              WR_REQ,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              CACHE_RREQ,
   output logic              CACHE_RD_EN,
   output logic [DATA_W-1:0] CACHE_DATA,
   output logic [ADDR_W:0]   CACHE_LEVEL,
   output logic              OVERFLOW,
`ifdef VGA_CACHE_STAT_EN
   output logic [15:0]       DROP_CNT,
   output logic [15:0]       STARVE_CNT,
`endif
   output logic              UNDERFLOW
);

   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_level;
   logic             r_overflow;
   logic             r_underflow;
   logic             r_rd_en;
   cache_state_e     r_state;

   logic             w_empty;
   logic             w_full;
   logic             w_wr_acc;
   logic             w_rd_acc;
   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic [PTR_W-1:0] w_level_nxt;
   cache_state_e     w_state_nxt;
   logic             w_ram_we;
   logic             w_ram_re;

   // Full/empty from the current pointers, before any pop this cycle
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign w_wr_acc = WR_REQ && !w_full;
   assign w_rd_acc = CACHE_RREQ && !w_empty;

   // Next pointers, level and FILL/STREAM state; flush overrides everything
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_state_nxt  = r_state;
      if (FRAME_SYNC) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
      end else begin
         w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_wr_acc);
         w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd_acc);
      end
      w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
      if (FRAME_SYNC) begin
         w_state_nxt = FILL;
      end else begin
         case (r_state)
            FILL:    if (w_level_nxt >= PTR_W'(RD_THRESH)) w_state_nxt = STREAM;
            STREAM:  if (w_level_nxt == '0)                w_state_nxt = FILL;
            default: w_state_nxt = FILL;
         endcase
      end
   end

   // Pointers, level, state and the delayed stream enable
   always_ff @(posedge CLK_40M or negedge RST_N) begin
      if (!RST_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_state  <= FILL;
         r_rd_en  <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
         r_state  <= w_state_nxt;
         r_rd_en  <= FRAME_SYNC ? 1'b0 : (r_state == STREAM);
      end
   end

   // Sticky error flags, cleared by a frame flush
   always_ff @(posedge CLK_40M or negedge RST_N) begin
      if (!RST_N) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (FRAME_SYNC) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (WR_REQ && w_full)      r_overflow  <= 1'b1;
         if (CACHE_RREQ && w_empty) r_underflow <= 1'b1;
      end
   end

`ifdef VGA_CACHE_STAT_EN
   logic [15:0] r_drop_cnt;
   logic [15:0] r_starve_cnt;

   // Saturating drop/starve event counters
   always_ff @(posedge CLK_40M or negedge RST_N) begin
      if (!RST_N) begin
         r_drop_cnt   <= '0;
         r_starve_cnt <= '0;
      end else if (FRAME_SYNC) begin
         r_drop_cnt   <= '0;
         r_starve_cnt <= '0;
      end else begin
         if (WR_REQ && w_full && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
         if (CACHE_RREQ && w_empty && (r_starve_cnt != 16'hFFFF))
            r_starve_cnt <= r_starve_cnt + 16'd1;
      end
   end

   assign DROP_CNT   = r_drop_cnt;
   assign STARVE_CNT = r_starve_cnt;
`endif

   // Head word is fetched at the next read pointer; hold it when going empty
   assign w_ram_we = w_wr_acc && !FRAME_SYNC;
   assign w_ram_re = !FRAME_SYNC && (w_wr_ptr_nxt != w_rd_ptr_nxt);

   vga_cache_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk   (CLK_40M),
      .i_rst_n (RST_N),
      .i_we    (w_ram_we),
      .i_waddr (r_wr_ptr[ADDR_W-1:0]),
      .i_wdata (WR_DATA),
      .i_re    (w_ram_re),
      .i_raddr (w_rd_ptr_nxt[ADDR_W-1:0]),
      .o_rdata (CACHE_DATA)
   );

   assign CACHE_RD_EN = r_rd_en;
   assign CACHE_LEVEL = r_level;
   assign OVERFLOW    = r_overflow;
   assign UNDERFLOW   = r_underflow;

endmodule
